// File: rtl/mc_seq_ctrl_if.sv
// Sequencer <-> datapath/memory signal bundle; slave = sequencer side, master = datapath side.
interface mc_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       Op;
  logic             Zero;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSel;
  logic             RegWrite;
  logic [1:0]       WBSel;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  Op, Zero, mem_ack,
    output mem_req, mem_we, IorD, IRWrite, PCWrite, PCSel, RegWrite, WBSel,
           trap, trap_cause, state, retired
  );

  modport master (
    output Op, Zero, mem_ack,
    input  mem_req, mem_we, IorD, IRWrite, PCWrite, PCSel, RegWrite, WBSel,
           trap, trap_cause, state, retired
  );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory req/ack, timeout trap, retire count.
// Strobes decode from state (IRWrite/PCWrite also see mem_ack/Zero); memory stalls hold state until ack or timeout.
module mc_seq_ctrl #(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rstn,
  mc_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JAL    = 3'd4,
    C_JALR   = 3'd5
  } cls_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  cls_t             r_cls;
  logic [TO_W-1:0]  r_to;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_ret;

  cls_t       w_cls;
  logic       w_legal;
  logic       w_mem_wait;
  logic       w_ack;
  logic       w_retire;
  logic [1:0] w_wbsel;

  always_comb begin
    w_cls   = C_ALU;
    w_legal = 1'b1;
    case (bus.Op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: w_cls = C_ALU;
      7'b0000011: w_cls = C_LOAD;
      7'b0100011: w_cls = C_STORE;
      7'b1100011: w_cls = C_BRANCH;
      7'b1101111: w_cls = C_JAL;
      7'b1100111: w_cls = C_JALR;
      default:    w_legal = 1'b0;
    endcase
  end

  // mem_ack only counts while a request is actually outstanding
  assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack      = w_mem_wait && bus.mem_ack;
  assign w_retire   = ((r_state == S_EXEC) && (r_cls == C_BRANCH)) ||
                      ((r_state == S_MEM) && (r_cls == C_STORE) && bus.mem_ack) ||
                      (r_state == S_WB);

  always_comb begin
    case (r_cls)
      C_LOAD:         w_wbsel = 2'b01;
      C_JAL, C_JALR:  w_wbsel = 2'b10;
      default:        w_wbsel = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cls   <= C_ALU;
      r_to    <= '0;
      r_cause <= 2'b00;
      r_ret   <= '0;
    end else begin
      if (w_retire) r_ret <= r_ret + 1'b1;
      // counter only runs while a request waits; any other cycle leaves it clear
      if (w_mem_wait && !bus.mem_ack) r_to <= r_to + 1'b1;
      else                            r_to <= '0;

      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ack) r_state <= S_DECODE;
          else if (r_to == TO_LAST) begin
            r_state <= S_TRAP;
            r_cause <= 2'b10;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_cls   <= w_cls;
            r_state <= S_EXEC;
          end else begin
            r_state <= S_TRAP;
            r_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          case (r_cls)
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_BRANCH:        r_state <= S_FETCH;
            default:         r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ack) r_state <= (r_cls == C_STORE) ? S_FETCH : S_WB;
          else if (r_to == TO_LAST) begin
            r_state <= S_TRAP;
            r_cause <= 2'b10;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSel    = 2'b00;
    bus.RegWrite = 1'b0;
    bus.WBSel    = 2'b00;
    bus.trap     = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.IRWrite = w_ack;
        bus.PCWrite = w_ack;
      end
      S_EXEC: begin
        bus.WBSel = w_wbsel;
        case (r_cls)
          C_BRANCH: begin
            bus.PCWrite = bus.Zero;
            bus.PCSel   = 2'b01;
          end
          C_JAL: begin
            bus.PCWrite = 1'b1;
            bus.PCSel   = 2'b10;
          end
          C_JALR: begin
            bus.PCWrite = 1'b1;
            bus.PCSel   = 2'b11;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
        bus.mem_we  = (r_cls == C_STORE);
        bus.WBSel   = w_wbsel;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.WBSel    = w_wbsel;
      end
      S_TRAP:  bus.trap = 1'b1;
      default: ;
    endcase
  end

  assign bus.trap_cause = r_cause;
  assign bus.state      = r_state;
  assign bus.retired    = r_ret;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Scoreboard bench for mc_seq_ctrl: stimulus pushes a per-cycle expected output snapshot, a negedge monitor pops and compares.
module tb_mc_seq_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk;
  logic rstn;

  mc_seq_ctrl_if #(.CNT_W(32)) bus ();

  mc_seq_ctrl #(.CNT_W(32), .TO_W(8), .MEM_TIMEOUT(200)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] exp_q [$];
  string       name_q [$];
  int          n_vec;
  int          n_bad;

  // snapshot: state, mem_req, mem_we, IorD, IRWrite, PCWrite, PCSel, RegWrite, WBSel, trap, trap_cause, retired
  function automatic logic [47:0] e(input logic [2:0] st, input logic rq, input logic we,
                                    input logic io, input logic irw, input logic pcw,
                                    input logic [1:0] pcs, input logic rw, input logic [1:0] wbs,
                                    input logic tr, input logic [1:0] cs, input logic [31:0] rt);
    return {st, rq, we, io, irw, pcw, pcs, rw, wbs, tr, cs, rt};
  endfunction

  task automatic cyc(input string nm, input logic rn, input logic [6:0] op,
                     input logic z, input logic ack, input logic [47:0] ex);
    @(posedge clk);
    #1;
    rstn        = rn;
    bus.Op      = op;
    bus.Zero    = z;
    bus.mem_ack = ack;
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  logic [47:0] m_got;
  logic [47:0] m_exp;
  string       m_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_got = {bus.state, bus.mem_req, bus.mem_we, bus.IorD, bus.IRWrite, bus.PCWrite,
               bus.PCSel, bus.RegWrite, bus.WBSel, bus.trap, bus.trap_cause, bus.retired};
      m_exp = exp_q.pop_front();
      m_nm  = name_q.pop_front();
      n_vec++;
      if (m_got !== m_exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", m_nm, m_got, m_exp);
      end
    end
  end

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rstn        = 1'b0;
    bus.Op      = 7'd0;
    bus.Zero    = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);

    // reset, then R-type with ack on third fetch cycle; Op garbled after DECODE
    cyc("rst",     0, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("idle",    1, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_f1",    1, OP_R,   0, 0, e(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_f2",    1, OP_R,   0, 0, e(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_f3",    1, OP_R,   0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_dec",   1, OP_R,   0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_exe",   1, OP_BAD, 0, 1, e(3,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("r_wb",    1, OP_BAD, 0, 0, e(5,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0));
    // lw with data ack on third MEM cycle
    cyc("lw_f",    1, OP_LW,  0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,1));
    cyc("lw_dec",  1, OP_LW,  0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1));
    cyc("lw_exe",  1, OP_LW,  0, 0, e(3,0,0,0,0,0,2'b00,0,2'b01,0,2'b00,1));
    cyc("lw_m1",   1, OP_LW,  0, 0, e(4,1,0,1,0,0,2'b00,0,2'b01,0,2'b00,1));
    cyc("lw_m2",   1, OP_LW,  0, 0, e(4,1,0,1,0,0,2'b00,0,2'b01,0,2'b00,1));
    cyc("lw_m3",   1, OP_LW,  0, 1, e(4,1,0,1,0,0,2'b00,0,2'b01,0,2'b00,1));
    cyc("lw_wb",   1, OP_LW,  0, 0, e(5,0,0,0,0,0,2'b00,1,2'b01,0,2'b00,1));
    // beq taken then not taken
    cyc("bt_f",    1, OP_BR,  0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,2));
    cyc("bt_dec",  1, OP_BR,  0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,2));
    cyc("bt_exe",  1, OP_BR,  1, 0, e(3,0,0,0,0,1,2'b01,0,2'b00,0,2'b00,2));
    cyc("bn_f",    1, OP_BR,  0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,3));
    cyc("bn_dec",  1, OP_BR,  0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,3));
    cyc("bn_exe",  1, OP_BR,  0, 0, e(3,0,0,0,0,0,2'b01,0,2'b00,0,2'b00,3));
    // sw, immediate ack
    cyc("sw_f",    1, OP_SW,  0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,4));
    cyc("sw_dec",  1, OP_SW,  0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,4));
    cyc("sw_exe",  1, OP_SW,  0, 0, e(3,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,4));
    cyc("sw_mem",  1, OP_SW,  0, 1, e(4,1,1,1,0,0,2'b00,0,2'b00,0,2'b00,4));
    // jal, jalr
    cyc("jal_f",   1, OP_JAL, 0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,5));
    cyc("jal_dec", 1, OP_JAL, 0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,5));
    cyc("jal_exe", 1, OP_JAL, 0, 0, e(3,0,0,0,0,1,2'b10,0,2'b10,0,2'b00,5));
    cyc("jal_wb",  1, OP_JAL, 0, 0, e(5,0,0,0,0,0,2'b00,1,2'b10,0,2'b00,5));
    cyc("jr_f",    1, OP_JR,  0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,6));
    cyc("jr_dec",  1, OP_JR,  0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,6));
    cyc("jr_exe",  1, OP_JR,  0, 0, e(3,0,0,0,0,1,2'b11,0,2'b10,0,2'b00,6));
    cyc("jr_wb",   1, OP_JR,  0, 0, e(5,0,0,0,0,0,2'b00,1,2'b10,0,2'b00,6));
    // illegal opcode traps and ignores stray acks
    cyc("ill_f",   1, OP_BAD, 0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,7));
    cyc("ill_dec", 1, OP_BAD, 0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,7));
    cyc("ill_t1",  1, OP_BAD, 0, 1, e(6,0,0,0,0,0,2'b00,0,2'b00,1,2'b01,7));
    cyc("ill_t2",  1, OP_BAD, 0, 0, e(6,0,0,0,0,0,2'b00,0,2'b00,1,2'b01,7));
    cyc("rst2",    0, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("idle2",   1, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    // fetch timeout: 200 cycles without ack
    for (int k = 1; k <= 200; k++)
      cyc("to_fetch", 1, OP_R, 0, 0, e(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("to_trap", 1, OP_R,   0, 0, e(6,0,0,0,0,0,2'b00,0,2'b00,1,2'b10,0));
    cyc("to_trap2",1, OP_R,   0, 1, e(6,0,0,0,0,0,2'b00,0,2'b00,1,2'b10,0));
    // ack on the 200th cycle wins over the timeout
    cyc("rst3",    0, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("idle3",   1, OP_R,   0, 0, e(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    for (int k = 1; k <= 199; k++)
      cyc("late_fetch", 1, OP_R, 0, 0, e(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("late_ack",1, OP_R,   0, 1, e(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0));
    cyc("late_dec",1, OP_R,   0, 0, e(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));
    cyc("late_exe",1, OP_R,   0, 0, e(3,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0));

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d snapshots left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath.
- Classifies the opcode held in the instruction register.
- Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB and drives PC/IR/register-file/memory enables.
- Arbitrates the single instruction/data memory port through a req/ack handshake with timeout, and keeps a retired-instruction counter.
- Sits beside the combinational decoder, which still supplies ALUOp/EXTOp/DMType.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TO_W, 8, width of memory-wait timeout counter.
- MEM_TIMEOUT, 200, cycles a request may wait for mem_ack before trapping (must be < 2^TO_W).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- Op  in  7  opcode from instruction register; valid from DECODE onward.
- Zero  in  1  ALU branch-condition result, valid in EXEC.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- IorD  out  1  address select: 0=PC, 1=ALU result.
- IRWrite  out  1  latch instruction and old PC.
- PCWrite  out  1  update PC.
- PCSel  out  2  00 PC+4, 01 branch target, 10 jal target, 11 jalr target.
- RegWrite  out  1  register-file write strobe.
- WBSel  out  2  00 ALU, 01 memory data, 10 old PC+4.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state  out  3  current state for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rstn=0, asynchronous, any state, including mid-handshake):
  - state=IDLE; retired=0; timeout count=0; trap=0; trap_cause=00.
  - Every strobe output is 0.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.
- IDLE: all outputs 0; next cycle FETCH.
- FETCH:
  - mem_req=1, IorD=0, mem_we=0.
  - On mem_ack: IRWrite=1, PCWrite=1, PCSel=00; next state DECODE.
- DECODE (one cycle, no strobes):
  - Op in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} -> EXEC.
  - Any other Op -> TRAP with cause 01.
- EXEC (one cycle):
  - R/I-ALU/lui/auipc -> WB, WBSel=00.
  - load/store -> MEM.
  - branch: PCWrite=Zero, PCSel=01; -> FETCH and the instruction retires.
  - jal: PCWrite=1, PCSel=10 -> WB, WBSel=10.
  - jalr: PCWrite=1, PCSel=11 -> WB, WBSel=10.
- MEM:
  - mem_req=1, IorD=1, mem_we=1 for store, 0 for load.
  - On mem_ack: store -> FETCH (retires); load -> WB, WBSel=01.
- WB: RegWrite=1 for exactly one cycle, WBSel held; -> FETCH; retires.
- Combinational decode: IRWrite, PCWrite and the FETCH-state PCWrite are Mealy outputs (state plus mem_ack/Zero). All other outputs are decoded from state and the opcode class.
- Opcode class is registered at DECODE exit, so Op changes after DECODE are ignored.
- Timeout:
  - Counter clears on entry to FETCH or MEM and on every mem_ack.
  - Increments each cycle mem_req=1 without ack.
  - Reaching MEM_TIMEOUT with no ack -> TRAP with cause 10; mem_req drops the same cycle.
  - mem_ack in the same cycle the count reaches MEM_TIMEOUT: the ack wins, no trap.
- TRAP: trap=1, all strobes 0; held until reset.
- mem_ack outside FETCH/MEM is ignored.
- retired increments by 1 on each retire event and wraps from 2^CNT_W-1 to 0.
- At most one retire per cycle.

Test Plan:
- Reset release, mem_ack on 3rd FETCH cycle, Op=0110011 -> states 0,1,1,1,2,3,5,1; RegWrite high exactly in state 5; retired=1.
- lw (Op=0000011), data ack after 2 cycles -> MEM with IorD=1, mem_we=0, then WB with WBSel=01; retired=1.
- beq: Zero=1 -> PCWrite=1, PCSel=01 in EXEC, next state FETCH. Zero=0 -> PCWrite=0. retired increments both times.
- sw (Op=0100011) -> mem_we=1 in MEM; no RegWrite; FETCH after ack.
- Op=1111111 -> TRAP, trap_cause=01, no further mem_req; rstn pulse -> IDLE, retired=0.
- No ack for 200 cycles in FETCH -> TRAP, trap_cause=10. Separately, ack exactly at cycle 200 -> DECODE, no trap.
